// File: rtl/tree_reduce_ctrl.sv
// -----------------------------------------------------------------------------
// tree_reduce_ctrl
//
// Sequencing controller for an external combinational saturating adder tree.
// A job of cfg_len beats is streamed in; each beat (LANES signed words) is
// driven onto the tree, and the tree's per-beat sum is folded into a
// saturating signed accumulator. The final scalar is returned over a
// valid/ready handshake together with a sticky "accumulator clamped" flag.
//
// Optional feature macro: TREE_REDUCE_PIPE_EN
//   Defined   : tree_out is registered (plus a valid bit) before it reaches
//               the accumulator; a one-cycle DRAIN state follows the last beat.
//   Undefined : tree_out feeds the accumulator directly; no DRAIN state.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous, active-high reset
//   start      in   job start pulse, sampled only in IDLE
//   cfg_len    in   beats in job, sampled with start (0 = empty job)
//   busy       out  high in any state other than IDLE
//   in_valid   in   beat valid
//   in_ready   out  beat accepted on in_valid && in_ready (ACCUM only)
//   in_data    in   beat words, lane 0 in the LSBs
//   tree_in    out  adder-tree input, equal to in_data
//   tree_out   in   adder-tree sum, combinational from tree_in
//   out_valid  out  result valid (DONE)
//   out_ready  in   result consumed on out_valid && out_ready
//   out_data   out  signed accumulated result
//   out_sat    out  sticky flag: accumulator clamped at least once this job
// -----------------------------------------------------------------------------
module tree_reduce_ctrl #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cfg_len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W*LANES-1:0] in_data,
  output logic [DATA_W*LANES-1:0] tree_in,
  input  logic [DATA_W-1:0]       tree_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_sat
);

`ifdef TREE_REDUCE_PIPE_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;
`endif

  localparam logic [DATA_W-1:0] ACC_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] ACC_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q,   acc_d;
  logic              sat_q,   sat_d;
  logic [LEN_W-1:0]  cnt_q,   cnt_d;
  logic [LEN_W-1:0]  len_q,   len_d;

  logic              in_fire;
  logic              add_en;
  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   sum_wide;
  logic              sum_ovf;

  // The tree owns no state; its input bus is a straight wire from upstream.
  assign tree_in = in_data;

  assign in_fire = (state_q == S_ACCUM) && in_valid;

`ifdef TREE_REDUCE_PIPE_EN
  logic [DATA_W-1:0] stage_q;
  logic              stage_vld_q;

  // Stage the tree sum so the accumulator adder sits behind a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
    end else begin
      stage_vld_q <= in_fire;
      if (in_fire) stage_q <= tree_out;
    end
  end

  assign addend = stage_q;
  assign add_en = stage_vld_q;
`else
  assign addend = tree_out;
  assign add_en = in_fire;
`endif

  // One extra bit of headroom: overflow shows up as the two top bits
  // disagreeing, and the top bit then tells which rail to clamp to.
  assign sum_wide = {acc_q[DATA_W-1], acc_q} + {addend[DATA_W-1], addend};
  assign sum_ovf  = sum_wide[DATA_W] ^ sum_wide[DATA_W-1];

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    if (add_en) begin
      if (sum_ovf) begin
        acc_d = sum_wide[DATA_W] ? ACC_MIN : ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_wide[DATA_W-1:0];
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = '0;
          len_d   = cfg_len;
          state_d = (cfg_len != '0) ? S_ACCUM : S_DONE;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
`ifdef TREE_REDUCE_PIPE_EN
            state_d = S_DRAIN;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef TREE_REDUCE_PIPE_EN
      // The staged last beat is folded in during this cycle.
      S_DRAIN: state_d = S_DONE;
`endif
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign out_data = acc_q;
  assign out_sat  = sat_q;

endmodule
